// File: rtl/xnor_pkg.sv
// Shared types, defaults and helpers for the XNOR popcount accumulator.
package xnor_pkg;

   localparam int WL_DEF     = 112;
   localparam int NCHUNK_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Tags that travel through the popcount pipeline next to each beat.
   typedef struct packed {
      logic start;
      logic add;
      logic last;
   } beat_tag_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/popcount_pipe.sv
// Two-stage popcount: stage 1 counts each half-word, stage 2 sums the halves.
module popcount_pipe
   import xnor_pkg::*;
#(
   parameter  int WL = WL_DEF,
   localparam int PW = clog2(WL + 1)
) (
   input  logic          clk_sys,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [WL-1:0] in_bits,
   output logic          out_valid,
   output logic [PW-1:0] out_count
);

   localparam int LW = WL / 2;

   logic [PW-1:0] cnt_lo;
   logic [PW-1:0] cnt_hi;
   logic [PW-1:0] s1_lo;
   logic [PW-1:0] s1_hi;
   logic          s1_vld;

   // Low half holds floor(WL/2) bits, high half holds the remaining ceil(WL/2).
   always_comb begin
      cnt_lo = '0;
      cnt_hi = '0;
      for (int i = 0; i < WL; i++) begin
         if (i < LW) cnt_lo = cnt_lo + PW'(in_bits[i]);
         else        cnt_hi = cnt_hi + PW'(in_bits[i]);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_lo     <= '0;
         s1_hi     <= '0;
         out_valid <= 1'b0;
         out_count <= '0;
      end else begin
         s1_vld    <= in_valid;
         s1_lo     <= cnt_lo;
         s1_hi     <= cnt_hi;
         out_valid <= s1_vld;
         out_count <= s1_lo + s1_hi;
      end
   end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Framed XNOR-popcount dot-product accumulator with optional binarising threshold.
// Define XNOR_ACC_THRESH_EN to build the obit comparator; otherwise obit is tied 0.
//
//   state | meaning
//   IDLE  | waiting for a beat with iFIRST
//   ACCUM | inside a vector, cnt beats accepted so far
module xnor_popcount_acc
   import xnor_pkg::*;
#(
   parameter  int WL     = WL_DEF,
   parameter  int NCHUNK = NCHUNK_DEF,
   localparam int OW     = clog2(WL * NCHUNK + 1)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iEN,
   input  logic          iFIRST,
   input  logic          iLAST,
   input  logic [WL-1:0] idata,
   input  logic [WL-1:0] iweight,
   input  logic [OW-1:0] ithresh,
   output logic [OW-1:0] odata,
   output logic          obit,
   output logic          oEN,
   output logic          oERR
);

   localparam int PW = clog2(WL + 1);
   localparam int CW = clog2(NCHUNK + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(NCHUNK);

   acc_state_e    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          err_nxt;
   logic          take;
   beat_tag_t     tag_in, s1_tag, s2_tag;

   logic          pc_vld;
   logic [PW-1:0] pc;
   logic [OW-1:0] acc, acc_nxt;
   logic          obit_nxt;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= IDLE;
         cnt   <= '0;
         oERR  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         oERR  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      take      = 1'b0;
      tag_in    = '0;
      if (iEN) begin
         if (iFIRST) begin
            take         = 1'b1;
            tag_in.start = 1'b1;
            tag_in.add   = 1'b1;
            cnt_nxt      = CNT_ONE;
            state_nxt    = ACCUM;
            err_nxt      = (state == ACCUM);
            if (iLAST) begin
               tag_in.last = 1'b1;
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               if (CNT_ONE != CNT_FULL) err_nxt = 1'b1;
            end
         end else if (state == IDLE) begin
            err_nxt = 1'b1;
         end else if (cnt != CNT_FULL) begin
            take       = 1'b1;
            tag_in.add = 1'b1;
            cnt_nxt    = cnt + CNT_ONE;
            if (iLAST) begin
               tag_in.last = 1'b1;
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               if (cnt + CNT_ONE != CNT_FULL) err_nxt = 1'b1;
            end
         end else begin
            // Overlong vector: drop the data but still close out on iLAST.
            err_nxt = 1'b1;
            if (iLAST) begin
               take        = 1'b1;
               tag_in.last = 1'b1;
               state_nxt   = IDLE;
               cnt_nxt     = '0;
            end
         end
      end
   end

   popcount_pipe #(.WL(WL)) u_popcount (
      .clk_sys   (iCLK),
      .rst       (iRST),
      .in_valid  (take),
      .in_bits   (~(idata ^ iweight)),
      .out_valid (pc_vld),
      .out_count (pc)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s1_tag <= '0;
         s2_tag <= '0;
      end else begin
         s1_tag <= tag_in;
         s2_tag <= s1_tag;
      end
   end

   always_comb begin
      acc_nxt = acc;
      if (s2_tag.add) acc_nxt = s2_tag.start ? OW'(pc) : acc + OW'(pc);
   end

`ifdef XNOR_ACC_THRESH_EN
   logic [OW-1:0] thr_s1, thr_s2;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         thr_s1 <= '0;
         thr_s2 <= '0;
      end else begin
         thr_s1 <= ithresh;
         thr_s2 <= thr_s1;
      end
   end

   assign obit_nxt = (acc_nxt >= thr_s2);
`else
   logic unused_thresh;
   assign unused_thresh = ^ithresh;
   assign obit_nxt      = 1'b0;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         acc   <= '0;
         odata <= '0;
         obit  <= 1'b0;
         oEN   <= 1'b0;
      end else begin
         oEN <= 1'b0;
         if (pc_vld) begin
            acc <= acc_nxt;
            if (s2_tag.last) begin
               odata <= acc_nxt;
               obit  <= obit_nxt;
               oEN   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Scoreboard bench for xnor_popcount_acc: directed framing cases plus randomized vectors.
module tb_xnor_popcount_acc;
   import xnor_pkg::*;

   localparam int WL     = 112;
   localparam int NCHUNK = 4;
   localparam int OW     = clog2(WL * NCHUNK + 1);

   logic          iCLK;
   logic          iRST;
   logic          iEN;
   logic          iFIRST;
   logic          iLAST;
   logic [WL-1:0] idata;
   logic [WL-1:0] iweight;
   logic [OW-1:0] ithresh;
   logic [OW-1:0] odata;
   logic          obit;
   logic          oEN;
   logic          oERR;

   xnor_popcount_acc #(.WL(WL), .NCHUNK(NCHUNK)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iEN     (iEN),
      .iFIRST  (iFIRST),
      .iLAST   (iLAST),
      .idata   (idata),
      .iweight (iweight),
      .ithresh (ithresh),
      .odata   (odata),
      .obit    (obit),
      .oEN     (oEN),
      .oERR    (oERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int cyc = 0;
   always @(posedge iCLK) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int data;
      bit b;
   } res_t;

   res_t res_q[$];
   int   err_q[$];
   res_t mon_r;
   int   chk_total = 0;
   int   chk_pass  = 0;

   // reference model: position inside the current vector
   bit m_in  = 1'b0;
   int m_n   = 0;
   int m_sum = 0;

   task automatic check(input string name, input int got, input int exp);
      chk_total++;
      if (got == exp) chk_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   always @(negedge iCLK) begin
      while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
         check("oen_missing", 0, res_q[0].cyc);
         void'(res_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
         check("oerr_missing", 0, err_q[0]);
         void'(err_q.pop_front());
      end
      if (oEN === 1'b1) begin
         if (res_q.size() == 0) begin
            check("oen_unexpected", cyc, -1);
         end else begin
            check("oen_cycle", cyc, res_q[0].cyc);
            if (res_q[0].cyc == cyc) begin
               mon_r = res_q.pop_front();
               check("odata", int'(odata), mon_r.data);
               check("obit", int'(obit), int'(mon_r.b));
            end
         end
      end
      if (oERR === 1'b1) begin
         if (err_q.size() == 0) begin
            check("oerr_unexpected", cyc, -1);
         end else begin
            check("oerr_cycle", cyc, err_q[0]);
            if (err_q[0] == cyc) void'(err_q.pop_front());
         end
      end
   end

   function automatic logic [WL-1:0] rand_vec();
      logic [WL-1:0] v;
      for (int i = 0; i < WL; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // weight giving exactly k matching bit positions against d
   function automatic logic [WL-1:0] match_w(input logic [WL-1:0] d, input int k);
      logic [WL-1:0] m;
      m = '1;
      m = m >> k;
      return d ^ m;
   endfunction

   task automatic drive(input bit en, input bit first, input bit last,
                        input logic [WL-1:0] d, input logic [WL-1:0] w, input int th);
      logic [WL-1:0] x;
      int  s, pc;
      bit  e, emit;
      iEN     = en;
      iFIRST  = first;
      iLAST   = last;
      idata   = d;
      iweight = w;
      ithresh = OW'(th);
      s       = cyc + 1;
      if (en) begin
         x    = ~(d ^ w);
         pc   = $countones(x);
         e    = 1'b0;
         emit = 1'b0;
         if (first) begin
            e     = m_in;
            m_in  = 1'b1;
            m_n   = 1;
            m_sum = pc;
            if (last) begin
               emit = 1'b1;
               if (m_n != NCHUNK) e = 1'b1;
            end
         end else if (!m_in) begin
            e = 1'b1;
         end else if (m_n < NCHUNK) begin
            m_n++;
            m_sum += pc;
            if (last) begin
               emit = 1'b1;
               if (m_n != NCHUNK) e = 1'b1;
            end
         end else begin
            e = 1'b1;
            if (last) emit = 1'b1;
         end
         if (emit) begin
            m_in = 1'b0;
`ifdef XNOR_ACC_THRESH_EN
            res_q.push_back('{s + 2, m_sum, m_sum >= th});
`else
            res_q.push_back('{s + 2, m_sum, 1'b0});
`endif
         end
         if (e) err_q.push_back(s);
      end
      @(posedge iCLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 0);
   endtask

   // reset for n cycles; optionally with a beat presented alongside the reset
   task automatic do_reset(input int n, input bit with_beat);
      int r;
      iRST    = 1'b1;
      iEN     = with_beat;
      iFIRST  = 1'b0;
      iLAST   = 1'b0;
      idata   = rand_vec();
      iweight = rand_vec();
      r       = cyc + 1;
      @(posedge iCLK);
      #1;
      while (res_q.size() > 0 && res_q[res_q.size()-1].cyc >= r) void'(res_q.pop_back());
      while (err_q.size() > 0 && err_q[err_q.size()-1] >= r) void'(err_q.pop_back());
      m_in  = 1'b0;
      m_n   = 0;
      m_sum = 0;
      check("rst_odata", int'(odata), 0);
      check("rst_obit", int'(obit), 0);
      check("rst_oen", int'(oEN), 0);
      check("rst_oerr", int'(oERR), 0);
      iEN = 1'b0;
      for (int i = 1; i < n; i++) begin
         @(posedge iCLK);
         #1;
      end
      iRST = 1'b0;
   endtask

   task automatic full_vec(input int k0, input int k1, input int k2, input int k3, input int th);
      int ks[4];
      logic [WL-1:0] d;
      ks = '{k0, k1, k2, k3};
      for (int b = 0; b < 4; b++) begin
         d = rand_vec();
         drive(1'b1, b == 0, b == 3, d, match_w(d, ks[b]), th);
      end
   endtask

   initial begin
      logic [WL-1:0] d;
      int len;
      iRST = 1'b0; iEN = 1'b0; iFIRST = 1'b0; iLAST = 1'b0;
      idata = '0; iweight = '0; ithresh = '0;

      do_reset(2, 1'b0);
      idle(2);

      // all-match vector, then all-mismatch vector
      full_vec(WL, WL, WL, WL, 300);
      idle(3);
      full_vec(0, 0, 0, 0, 1);
      idle(3);

      // back-to-back vectors, partial then full match
      full_vec(10, 20, 30, 40, 50);
      full_vec(WL, WL, WL, WL, 449);
      idle(4);

      // short vector: iLAST on beat 3
      for (int b = 0; b < 3; b++) begin
         d = rand_vec();
         drive(1'b1, b == 0, b == 2, d, match_w(d, 7 * (b + 1)), 40);
      end
      idle(1);
      // stray beat in IDLE, with and without iLAST
      d = rand_vec();
      drive(1'b1, 1'b0, 1'b0, d, d, 0);
      drive(1'b1, 1'b0, 1'b1, d, d, 0);
      idle(3);

      // restart mid-vector, then overlong vector closed by a dropped iLAST beat
      d = rand_vec();
      drive(1'b1, 1'b1, 1'b0, d, match_w(d, 5), 0);
      drive(1'b1, 1'b1, 1'b0, d, match_w(d, 11), 0);
      for (int b = 0; b < 4; b++) begin
         d = rand_vec();
         drive(1'b1, 1'b0, b == 3, d, match_w(d, 3 + b), 100);
      end
      idle(3);
      // one-beat vector is illegal at NCHUNK=4 but still emits
      d = rand_vec();
      drive(1'b1, 1'b1, 1'b1, d, match_w(d, 60), 60);
      idle(3);

      // iEN gaps inside a vector with junk on the framing inputs
      for (int b = 0; b < 4; b++) begin
         d = rand_vec();
         drive(1'b1, b == 0, b == 3, d, match_w(d, 25 * b), 150);
         drive(1'b0, 1'b1, 1'b1, rand_vec(), rand_vec(), 0);
      end
      idle(3);

      // reset on beat 2, then a clean vector
      d = rand_vec();
      drive(1'b1, 1'b1, 1'b0, d, d, 0);
      do_reset(1, 1'b1);
      full_vec(WL, 90, WL, 1, 300);
      // reset right behind an iLAST beat: the in-flight result is lost
      do_reset(1, 1'b0);
      idle(4);
      full_vec(50, 60, 70, 80, 260);
      idle(3);

      for (int v = 0; v < 150; v++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            d = rand_vec();
            drive(1'b1, (b == 0) || ($urandom_range(0, 19) == 0), b == len - 1,
                  d, d ^ (rand_vec() & rand_vec() & rand_vec()), $urandom_range(250, 448));
         end
      end
      idle(6);

      check("results_pending", res_q.size(), 0);
      check("errors_pending", err_q.size(), 0);
      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule

// File: doc/xnor_popcount_acc.md
XNOR_POPCOUNT_ACC -- requirements
Module: xnor_popcount_acc

Interface
REQ-001 SHALL have parameter WL, default 112: bits per input beat.
REQ-002 SHALL have parameter NCHUNK, default 4: beats per complete dot product, legal range 1..64.
REQ-003 SHALL have derived localparam OW = clog2(WL*NCHUNK+1): result width; 9 at defaults.
REQ-004 SHALL use one clock, iCLK; reset is synchronous and active-high.
REQ-005 iCLK  input  1  clock, all logic on rising edge.
REQ-006 iRST  input  1  synchronous active-high reset.
REQ-007 iEN  input  1  beat valid.
REQ-008 iFIRST  input  1  first beat of a vector; qualified by iEN.
REQ-009 iLAST  input  1  last beat of a vector; qualified by iEN.
REQ-010 idata  input  WL  activation bits.
REQ-011 iweight  input  WL  weight bits.
REQ-012 ithresh  input  OW  activation threshold; sampled on the iLAST beat.
REQ-013 odata  output  OW  accumulated XNOR popcount.
REQ-014 obit  output  1  binarised activation.
REQ-015 oEN  output  1  one-cycle pulse; odata/obit valid.
REQ-016 oERR  output  1  one-cycle pulse; framing error.

Function
REQ-017 SHALL compute per beat pc = number of ones in (idata XNOR iweight), range 0..WL.
REQ-018 SHALL compute pc in two registered stages: stage 1 = two half-word popcounts (ceil(WL/2), floor(WL/2)); stage 2 = their sum.
REQ-019 SHALL keep FSM states IDLE and ACCUM plus a beat counter cnt of clog2(NCHUNK+1) bits.
REQ-020 In IDLE, a beat with iFIRST=1 SHALL enter ACCUM, set cnt=1 and mark the beat "start".
REQ-021 In IDLE, a beat with iFIRST=0 SHALL be dropped, with oERR pulsing.
REQ-022 In ACCUM, a beat with iFIRST=1 SHALL discard the partial sum, restart with cnt=1 and pulse oERR.
REQ-023 In ACCUM, a beat with iFIRST=0 and cnt<NCHUNK SHALL be accepted and increment cnt.
REQ-024 In ACCUM, a beat with iFIRST=0 and cnt==NCHUNK SHALL be dropped and pulse oERR.
- If that dropped beat carries iLAST, the result is still emitted and the FSM returns to IDLE.
REQ-025 An accepted iLAST beat SHALL return the FSM to IDLE; if cnt after the beat != NCHUNK, oERR SHALL also pulse.
REQ-026 iFIRST=iLAST=1 on one beat SHALL form a one-beat vector (legal only when NCHUNK=1; otherwise oERR).
REQ-027 The accumulator SHALL load pc on a start beat and add pc otherwise.
- Tags (start, last, ithresh) SHALL be piped alongside pc.
- The accumulator cannot overflow OW.
REQ-028 Latency: oEN SHALL pulse exactly 3 cycles after the iLAST beat is sampled.
- odata and obit SHALL hold their value until the next oEN.
REQ-029 Back-to-back vectors with no idle cycle SHALL be supported at full rate (one beat per cycle).
REQ-030 oERR SHALL pulse 1 cycle after the offending beat.
REQ-031 Cycles with iEN=0 SHALL not alter FSM, cnt or accumulator; in-flight pipeline stages still advance.

Reset
REQ-032 iRST=1 SHALL force on the next edge:
- FSM=IDLE, cnt=0, accumulator=0, all pipeline valids=0;
- odata=0, obit=0, oEN=0, oERR=0.
REQ-033 Reset mid-vector or mid-pipeline SHALL discard all in-flight beats; no oEN follows.

Configuration
REQ-034 Macro XNOR_ACC_THRESH_EN defined: obit SHALL be 1 when odata >= the sampled ithresh (unsigned), else 0, registered with odata.
REQ-035 Macro XNOR_ACC_THRESH_EN undefined: obit SHALL be tied 0, ithresh unused, and no comparator built.

Structure
REQ-036 A shared package xnor_pkg SHALL hold:
- the FSM state enum (IDLE, ACCUM);
- a clog2 function;
- default constants WL_DEF=112 and NCHUNK_DEF=4.
REQ-037 The popcount SHALL be one sub-module, popcount_pipe (parameter WL, 2-cycle latency, valid in/out).

Verification
REQ-038 Defaults, 4 beats with idata=iweight (all match), ithresh=300 -> oEN 3 cycles after iLAST, odata=448, obit=1, oERR=0.
REQ-039 Defaults, 4 beats with idata=~iweight, ithresh=1 -> odata=0, obit=0.
REQ-040 Two vectors back-to-back (beats with 10, 20, 30, 40 matches, then 4×112 matches) -> oEN on consecutive result cycles, odata=100 then 448.
REQ-041 iLAST on beat 3 of NCHUNK=4 -> oEN with partial sum, plus oERR pulse.
- Beat in IDLE without iFIRST -> oERR only, no oEN.
REQ-042 iRST asserted on beat 2 of a vector -> all outputs 0 next cycle, no oEN.
- A following clean vector produces a correct result.
REQ-043 Macro XNOR_ACC_THRESH_EN undefined, all-match vector -> odata=448, obit=0.
